// File: rtl/mem_share_arb.sv
// Round-robin arbiter sharing one single-port register array among NREQ requesters, with bounded lock bursts.
// Latency: writes land at the accept edge; read data is presented one cycle after the accept edge.
// Backpressure: at most one req_ready per cycle; an ungranted requester holds its request until accepted.
module mem_share_arb #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ-1:0]     req_lock,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_wdata,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_rdata,
  output logic [IDW-1:0]      owner,
  output logic                locked
);

  localparam int DEPTH = 2**AW;
  localparam int HW    = $clog2(MAX_HOLD + 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     scan_idx;
  logic [AW-1:0]    addr_arr  [NREQ];
  logic [DW-1:0]    wdata_arr [NREQ];
  logic             sel_we, sel_lock, mem_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic [HW-1:0]    hold_inc;

  // Wrap an id to the next requester, modulo NREQ rather than 2**IDW.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] v);
    return (v == LAST_ID) ? '0 : v + IDW'(1);
  endfunction

  // Unpack the per-requester address and write-data buses.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_arr[k]  = req_addr[k*AW +: AW];
      wdata_arr[k] = req_wdata[k*DW +: DW];
    end
  end

  // Grant selection: owner-only while locked, else first valid scanning up from ptr.
  // The descending loop lets the lowest offset from ptr overwrite the others.
  always_comb begin
    req_ready = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        gnt_idx = owner_q;
        gnt_vld = req_valid[owner_q];
      end else begin
        for (int i = NREQ - 1; i >= 0; i--) begin
          scan_idx = {1'b0, ptr_q} + (IDW+1)'(i);
          if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
          if (req_valid[scan_idx[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan_idx[IDW-1:0];
          end
        end
      end
      req_ready[gnt_idx] = gnt_vld;
    end
  end

  // Next-state, pointer, lock counter and read-response computation.
  always_comb begin
    sel_we      = req_we[gnt_idx];
    sel_lock    = req_lock[gnt_idx];
    sel_addr    = addr_arr[gnt_idx];
    sel_wdata   = wdata_arr[gnt_idx];
    mem_we      = gnt_vld & sel_we;
    hold_inc    = hold_cnt_q + HW'(1);
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;

    if (gnt_vld && !sel_we) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_rdata_d = mem_q[sel_addr];
    end

    case (state_q)
      ST_ARB: begin
        if (gnt_vld) begin
          if (sel_lock && (MAX_HOLD > 1)) begin
            state_d    = ST_LOCKED;
            owner_d    = gnt_idx;
            hold_cnt_d = HW'(1);
          end else begin
            ptr_d = next_id(gnt_idx);
          end
        end
      end
      ST_LOCKED: begin
        // Release on owner idle, lock drop, or reaching the burst limit.
        if (!gnt_vld || !sel_lock || (hold_inc == HW'(MAX_HOLD))) begin
          state_d    = ST_ARB;
          ptr_d      = next_id(owner_q);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Array storage is deliberately not reset; writes are already gated off during reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[sel_addr] <= sel_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign owner     = owner_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_share_arb.sv
// Directed bench for mem_share_arb with a cycle-tagged read-response scoreboard.
// Stimulus changes #1 after the rising edge; outputs are sampled on the falling edge.
// The response monitor runs independently of the stimulus process.
module tb_mem_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld, we, lk;
  logic [4:0]  a [4];
  logic [7:0]  d [4];
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic [1:0]  owner;
  logic        locked;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  exp_t sbq [$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      req_addr[k*5 +: 5]  = a[k];
      req_wdata[k*8 +: 8] = d[k];
    end
  end

  mem_share_arb #(.NREQ(4), .DW(8), .AW(5), .IDW(2), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld),
    .req_ready (req_ready),
    .req_we    (we),
    .req_lock  (lk),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .owner     (owner),
    .locked    (locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int k, input bit v, input bit w, input bit l,
                         input logic [4:0] ad, input logic [7:0] dt);
    vld[k] = v;
    we[k]  = w;
    lk[k]  = l;
    a[k]   = ad;
    d[k]   = dt;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  // One cycle: check grant/lock at the falling edge, book any expected read response, advance.
  task automatic step(input string name, input logic [3:0] exp_rdy, input bit exp_locked,
                      input bit exp_rd, input logic [7:0] exp_dat);
    logic [1:0] id;
    id = 2'd0;
    @(negedge clk);
    chk({name, " req_ready"}, {28'd0, req_ready}, {28'd0, exp_rdy});
    chk({name, " locked"}, {31'd0, locked}, {31'd0, exp_locked});
    if (exp_rd) begin
      for (int k = 0; k < 4; k++) if (exp_rdy[k]) id = 2'(k);
      sbq.push_back('{cyc: cyc + 1, id: id, dat: exp_dat});
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest booked read in its exact cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        n_tests++;
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d data=0x%0h, no read due in cycle %0d",
                   rsp_id, rsp_rdata, cyc);
        end else begin
          if (rsp_id !== sbq[0].id || rsp_rdata !== sbq[0].dat) begin
            n_fail++;
            $display("FAIL rsp_data: got id=%0d data=0x%0h expected id=%0d data=0x%0h (cycle %0d)",
                     rsp_id, rsp_rdata, sbq[0].id, sbq[0].dat, cyc);
          end
          void'(sbq.pop_front());
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_missing: got no response, expected id=%0d data=0x%0h in cycle %0d",
                 sbq[0].id, sbq[0].dat, sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1'b1;
    vld = 4'hF;
    // Reset: grants forced off even with everyone requesting.
    step("rst0", 4'b0000, 1'b0, 1'b0, 8'h00);
    step("rst1", 4'b0000, 1'b0, 1'b0, 8'h00);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst owner", {30'd0, owner}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Preload mem[k] = 0x10+k, all four writing at once; round robin from 0.
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b1, 1'b0, 5'(k), 8'h10 + 8'(k));
    for (int k = 0; k < 4; k++) begin
      step("preload", 4'(1 << k), 1'b0, 1'b0, 8'h00);
      vld[k] = 1'b0;
    end

    // Test 1: continuous reads from all four -> 0,1,2,3,0,1,2,3 with no bubble.
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 1'b0, 5'(k), 8'h00);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) step("t1 rr", 4'(1 << k), 1'b0, 1'b1, 8'h10 + 8'(k));
    idle_all();

    // Test 2: req 2 writes A5 to addr 5, req 0 reads it back on the next edge.
    set_req(2, 1'b1, 1'b1, 1'b0, 5'd5, 8'hA5);
    step("t2 wr", 4'b0100, 1'b0, 1'b0, 8'h00);
    chk("t2 rsp_valid after write", {31'd0, rsp_valid}, 32'd0);
    chk("t2 rsp_rdata held", {24'd0, rsp_rdata}, 32'h13);
    idle_all();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
    step("t2 rd", 4'b0001, 1'b0, 1'b1, 8'hA5);
    idle_all();

    // Test 3: ptr=1, req 1 locks for MAX_HOLD=4 accepts while 0 and 3 wait.
    set_req(1, 1'b1, 1'b0, 1'b1, 5'd1, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(3, 1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
    step("t3 lock0", 4'b0010, 1'b0, 1'b1, 8'h11);
    chk("t3 owner", {30'd0, owner}, 32'd1);
    step("t3 lock1", 4'b0010, 1'b1, 1'b1, 8'h11);
    step("t3 lock2", 4'b0010, 1'b1, 1'b1, 8'h11);
    step("t3 lock3", 4'b0010, 1'b1, 1'b1, 8'h11);
    chk("t3 forced release", {31'd0, locked}, 32'd0);
    vld[1] = 1'b0;
    step("t3 next3", 4'b1000, 1'b0, 1'b1, 8'h13);
    vld[3] = 1'b0;
    step("t3 next0", 4'b0001, 1'b0, 1'b1, 8'h10);
    idle_all();

    // Test 4: ptr=1, req 3 locks, two accepts, then drops valid -> release, ptr wraps to 0.
    set_req(3, 1'b1, 1'b0, 1'b1, 5'd3, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    step("t4 lock0", 4'b1000, 1'b0, 1'b1, 8'h13);
    step("t4 lock1", 4'b1000, 1'b1, 1'b1, 8'h13);
    vld[3] = 1'b0;
    step("t4 drop", 4'b0000, 1'b1, 1'b0, 8'h00);
    chk("t4 released", {31'd0, locked}, 32'd0);
    step("t4 next0", 4'b0001, 1'b0, 1'b1, 8'h10);
    idle_all();

    // Test 5: reset on the edge of a locked read -> no access, response dropped.
    set_req(1, 1'b1, 1'b0, 1'b1, 5'd1, 8'h00);
    step("t5 lock", 4'b0010, 1'b0, 1'b1, 8'h11);
    rst = 1'b1;
    step("t5 rst", 4'b0000, 1'b1, 1'b0, 8'h00);
    chk("t5 locked after rst", {31'd0, locked}, 32'd0);
    chk("t5 rsp_valid after rst", {31'd0, rsp_valid}, 32'd0);
    chk("t5 owner after rst", {30'd0, owner}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 1'b0, 5'(k), 8'h00);
    step("t5 first", 4'b0001, 1'b0, 1'b1, 8'h10);
    idle_all();

    // Test 6: ten idle cycles, then a lone req 2 write granted immediately and read back.
    for (int i = 0; i < 10; i++) step("t6 idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    chk("t6 rsp_valid idle", {31'd0, rsp_valid}, 32'd0);
    set_req(2, 1'b1, 1'b1, 1'b0, 5'd7, 8'h3C);
    step("t6 wr", 4'b0100, 1'b0, 1'b0, 8'h00);
    set_req(2, 1'b1, 1'b0, 1'b0, 5'd7, 8'h00);
    step("t6 rd", 4'b0100, 1'b0, 1'b1, 8'h3C);
    idle_all();

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_share_arb.md
Name: mem_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-port register array (DEPTH x DW, default 32 x 8) between NREQ requesters.
- Each requester has a valid/ready request channel: write or read, address and write data.
- One access is performed per clock; read data returns on a shared response channel tagged with the requester id.
- An optional lock lets one requester keep the array for a bounded burst of back-to-back accesses.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width
AW, 5, address width; DEPTH = 2**AW
IDW, 2, requester id width; must satisfy 2**IDW >= NREQ
MAX_HOLD, 4, maximum accepted accesses per locked tenure (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept; at most one bit high
req_we  in  NREQ  1 = write, 0 = read
req_lock  in  NREQ  request to keep ownership after this access
req_addr  in  NREQ*AW  packed addresses; requester k uses bits [k*AW +: AW]
req_wdata  in  NREQ*DW  packed write data; requester k uses bits [k*DW +: DW]
rsp_valid  out  1  read data valid (one-cycle pulse per accepted read)
rsp_id  out  IDW  requester index of the read being answered
rsp_rdata  out  DW  read data
owner  out  IDW  current lock owner (meaningful only while locked)
locked  out  1  high in state LOCKED

Behaviour:
- Reset (rst sampled high at a clock edge):
  - state=ARB, ptr=0, hold_cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_rdata=0, owner=0, locked=0.
  - Array contents are not reset.
  - While rst is high, req_ready is forced all-zero; no access occurs.
- req_ready is combinational from req_valid, state, ptr and owner. It must never depend on req_ready itself.
- Accept: requester k is accepted when req_valid[k] & req_ready[k] at a rising edge. A requester must hold valid, we, addr and wdata stable until accepted.
- ARB state:
  - Grant the first k with req_valid[k] high, scanning ptr, ptr+1, ... modulo NREQ.
  - If no valid requests, grant none.
  - On accept of k:
    - req_lock[k]=0: ptr <= (k+1) mod NREQ.
    - req_lock[k]=1 and MAX_HOLD > 1: state <= LOCKED, owner <= k, hold_cnt <= 1, ptr unchanged.
    - req_lock[k]=1 and MAX_HOLD == 1: behaves as the unlocked case.
- LOCKED state:
  - Only the owner may be granted: req_ready[owner] = req_valid[owner]; all other bits are 0.
  - Owner accepted, and (req_lock[owner]=0 or hold_cnt+1 == MAX_HOLD): state <= ARB, ptr <= (owner+1) mod NREQ, hold_cnt <= 0. This is a forced release on the count limit.
  - Owner accepted otherwise: hold_cnt <= hold_cnt+1.
  - Owner req_valid low at an edge: no grant that cycle; state <= ARB, ptr <= (owner+1) mod NREQ, hold_cnt <= 0.
- Access timing:
  - Accepted write stores wdata at the accept edge.
  - Accepted read captures mem[addr] at the accept edge into rsp_rdata, with rsp_valid=1 and rsp_id=k in the following cycle (latency 1).
  - rsp_valid is 0 in any cycle following a non-read edge.
  - rsp_rdata holds its last value when rsp_valid is 0.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new data. No bypass is needed because the two are on different edges.
- Throughput: one access per cycle, with no bubble between different requesters in ARB.
- Reset mid-lock: returns to ARB with ptr=0. An in-flight read response is dropped: rsp_valid=0 on the cycle after the reset edge.
- Widths: ptr, owner and rsp_id are IDW bits; wrap is computed modulo NREQ, not 2**IDW. hold_cnt is wide enough to hold MAX_HOLD.

Test Plan:
1. Reset then all four requesters issue back-to-back reads with lock=0 and valid held continuously -> grants 0,1,2,3,0,... one per cycle; each rsp_valid pulse arrives one cycle after its accept with rsp_id equal to the granted index.
2. Req 2 writes 8'hA5 to addr 5, then req 0 reads addr 5 on the next cycle -> rsp_rdata=8'hA5, rsp_id=0, one cycle after the read accept.
3. Req 1 holds lock=1 and valid with MAX_HOLD=4 while req 0 and req 3 are also valid -> req 1 is granted 4 consecutive cycles, then locked falls and the next grant goes to 2 if valid, else 3; req 0 waits.
4. Req 3 locks, then drops valid for one cycle after 2 accepts -> no grant that cycle, locked=0 next cycle, ptr=0, req 0 is granted next.
5. rst is asserted on the edge where a read is accepted in the LOCKED state -> next cycle rsp_valid=0, locked=0, req_ready all zero during reset; after release, req 0 wins first among all-valid requesters.
6. No requests for 10 cycles -> req_ready=0, rsp_valid=0, ptr unchanged; then a single req 2 write -> granted in the same cycle it raises valid.
